alu_seq_arbiter: RTL and testbench

Shares one 4-bit add/subtract slice between two requesters and runs WIDTH-bit add or subtract on it, one nibble per cycle, LSB nibble first. A round-robin arbiter picks one requester per transaction. The block holds the carry between nibbles and builds the wide sum, carry-out and signed overflow. It sits between the operand producers and the 4-bit adder datapath, so a wide ALU costs the area of a single nibble adder.

---
 rtl/alu_seq_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_seq_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq_arbiter.sv
// Two-requester WIDTH-bit add/subtract sharing one 4-bit slice, one nibble per cycle.
// Define ALU_SEQ_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_seq_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carryout,
  output logic             rsp_overflow
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   a_reg, b_reg, result;
  logic               carry;
  logic               id;
  logic [CNT_W-1:0]   cnt;
  logic               grant0, grant1;
  logic               sel_sub;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [4:0]         slice;
  logic               last_nib;

`ifndef ALU_SEQ_FIXED_PRIO_EN
  logic               last_grant;
`endif

  // Grant is only offered from IDLE, so ready is low in RUN and DONE.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
`ifdef ALU_SEQ_FIXED_PRIO_EN
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
`else
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`endif
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel_a   = grant1 ? req1_a   : req0_a;
  assign sel_b   = grant1 ? req1_b   : req0_b;
  assign sel_sub = grant1 ? req1_sub : req0_sub;

  assign slice    = {1'b0, a_reg[4*int'(cnt) +: 4]} + {1'b0, b_reg[4*int'(cnt) +: 4]} + {4'b0, carry};
  assign last_nib = (cnt == CNT_W'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (grant0 || grant1) next_state = RUN;
      RUN:  if (last_nib)         next_state = DONE;
      DONE: if (rsp_ready)        next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      carry  <= 1'b0;
      id     <= 1'b0;
      cnt    <= '0;
`ifndef ALU_SEQ_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      if (grant0 || grant1) begin
        a_reg <= sel_a;
        b_reg <= sel_sub ? ~sel_b : sel_b;
        carry <= sel_sub;
        cnt   <= '0;
        id    <= grant1;
`ifndef ALU_SEQ_FIXED_PRIO_EN
        last_grant <= grant1;
`endif
      end else if (state == RUN) begin
        result[4*int'(cnt) +: 4] <= slice[3:0];
        carry                    <= slice[4];
        cnt                      <= cnt + 1'b1;
      end
    end
  end

  assign rsp_valid    = (state == DONE);
  assign rsp_id       = id;
  assign rsp_sum      = result;
  assign rsp_carryout = carry;
  // b_reg already holds ~b for subtract, so this is the usual add-overflow rule.
  assign rsp_overflow = (a_reg[WIDTH-1] & b_reg[WIDTH-1] & ~result[WIDTH-1]) |
                        (~a_reg[WIDTH-1] & ~b_reg[WIDTH-1] & result[WIDTH-1]);
endmodule

// File: tb/tb_alu_seq_arbiter.sv
// Directed self-checking bench for alu_seq_arbiter at WIDTH=16.
module tb_alu_seq_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_sub;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carryout, rsp_overflow;
  logic [15:0] rsp_sum;

  int checks   = 0;
  int failures = 0;

  alu_seq_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_carryout(rsp_carryout), .rsp_overflow(rsp_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; drives one request, checks latency and response.
  task automatic run_op(input bit rid, input logic [15:0] a, input logic [15:0] b, input bit sub,
                        input logic [15:0] exp_sum, input bit exp_c, input bit exp_ov, input string tag);
    int n;
    int lat;
    if (rid) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub; end
    else     begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub; end
    n = 0;
    while (!(rid ? req1_ready : req0_ready) && n < 20) begin @(negedge clk); n++; end
    check({tag, "_ready"}, {31'b0, rid ? req1_ready : req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    check({tag, "_latency"}, lat, 32'd5);
    check({tag, "_sum"}, {16'b0, rsp_sum}, {16'b0, exp_sum});
    check({tag, "_carry"}, {31'b0, rsp_carryout}, {31'b0, exp_c});
    check({tag, "_ovf"}, {31'b0, rsp_overflow}, {31'b0, exp_ov});
    check({tag, "_id"}, {31'b0, rsp_id}, {31'b0, rid});
    @(negedge clk);
    check({tag, "_handoff"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int got_ids [4];
    int k;
    logic [15:0] held;
    logic exp_second;

    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_id", {31'b0, rsp_id}, 32'd0);
    check("rst_sum", {16'b0, rsp_sum}, 32'd0);
    check("rst_carry", {31'b0, rsp_carryout}, 32'd0);
    check("rst_ovf", {31'b0, rsp_overflow}, 32'd0);
    check("rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "add1");
    run_op(1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub1");
    run_op(1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, "sub2");
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
    run_op(1'b1, 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, "ovf_neg");
    run_op(1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf_sub");

    // Arbitration with both requesters held valid.
    do_reset();
    req0_a = 16'h0001; req0_b = 16'h0002; req0_sub = 1'b0;
    req1_a = 16'h000A; req1_b = 16'h0014; req1_sub = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    k = 0; n = 0;
    while (k < 4 && n < 100) begin
      @(negedge clk); n++;
      if (rsp_valid) begin
        got_ids[k] = int'(rsp_id);
        check("arb_sum", {16'b0, rsp_sum}, rsp_id ? 32'h0000FFF6 : 32'h00000003);
        k++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("arb_count", k, 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_SEQ_FIXED_PRIO_EN
      check("arb_id", got_ids[i], 32'd0);
`else
      check("arb_id", got_ids[i], i % 2);
`endif
    end
    @(negedge clk);
    @(negedge clk);

    // Backpressure: response must hold, no grants while DONE.
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    held = rsp_sum;
    check("bp_first_sum", {16'b0, held}, 32'h0003);
    check("bp_first_id", {31'b0, rsp_id}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_sum", {16'b0, rsp_sum}, {16'b0, held});
      check("bp_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
`ifdef ALU_SEQ_FIXED_PRIO_EN
    exp_second = 1'b0;
`else
    exp_second = 1'b1;
`endif
    check("bp_regrant", {30'b0, req1_ready, req0_ready}, exp_second ? 32'd2 : 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("bp_second_id", {31'b0, rsp_id}, {31'b0, exp_second});
    @(negedge clk);

    // Reset mid-operation aborts silently.
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_sub = 1'b0;
    n = 0;
    while (!req0_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_valid", {31'b0, rsp_valid}, 32'd0);
    check("abort_sum", {16'b0, rsp_sum}, 32'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    check("abort_no_rsp", n, 32'd0);
    run_op(1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
